// File: rtl/log_event_arbiter.sv
// Shares one log-event sink among NB_REQ requesters: filters events below the programmed verbosity,
// grants by highest severity with round-robin among ties, and timestamps accepted events into a one-entry register.
module log_event_arbiter #(
  parameter int NB_REQ = 4,
  parameter int ID_W   = 8,
  parameter int TS_W   = 32,
  localparam int SRC_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [2:0]             verbosity,
  input  logic [NB_REQ-1:0]      req_valid,
  output logic [NB_REQ-1:0]      req_ready,
  input  logic [3*NB_REQ-1:0]    req_level,
  input  logic [ID_W*NB_REQ-1:0] req_msgid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_level,
  output logic [ID_W-1:0]        out_msgid,
  output logic [SRC_W-1:0]       out_src,
  output logic [TS_W-1:0]        out_time,
  output logic [15:0]            filtered_cnt
);

  localparam logic [SRC_W:0] NB_L = (SRC_W+1)'(NB_REQ);

  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_next;

  logic [TS_W-1:0]   ts;
  logic [SRC_W-1:0]  ptr, ptr_next, winner, cand;
  logic [SRC_W:0]    cand_sum, win_sum;
  logic [2:0]        lvl [NB_REQ];
  logic [2:0]        vmin, max_lvl;
  logic [NB_REQ-1:0] filt, elig;
  logic [ID_W-1:0]   win_msgid;
  logic [4:0]        nfilt;
  logic [16:0]       cnt_sum;
  logic              slot_free, grant, found;

  // Out-of-range levels and verbosity settings clamp into the debug..error range.
  function automatic logic [2:0] clamp_level(input logic [2:0] l);
    if (l == 3'd0) return 3'd1;
    if (l > 3'd5) return 3'd5;
    return l;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    vmin    = clamp_level(verbosity);
    filt    = '0;
    elig    = '0;
    max_lvl = 3'd0;
    nfilt   = 5'd0;
    for (int i = 0; i < NB_REQ; i++) begin
      lvl[i] = clamp_level(req_level[3*i +: 3]);
      if (req_valid[i]) begin
        if (lvl[i] < vmin) begin
          filt[i] = 1'b1;
          nfilt   = nfilt + 5'd1;
        end else begin
          elig[i] = 1'b1;
          if (lvl[i] > max_lvl) max_lvl = lvl[i];
        end
      end
    end
  end

  // Scan from the pointer with wrap-around; the first top-severity candidate wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = '0;
    cand_sum = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      cand_sum = {1'b0, ptr} + (SRC_W+1)'(k);
      if (cand_sum >= NB_L) cand_sum = cand_sum - NB_L;
      cand = cand_sum[SRC_W-1:0];
      if (!found && elig[cand] && lvl[cand] == max_lvl) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    win_msgid = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (SRC_W'(i) == winner) win_msgid = req_msgid[ID_W*i +: ID_W];
    end
    win_sum = {1'b0, winner} + (SRC_W+1)'(1);
    if (win_sum >= NB_L) win_sum = '0;
    ptr_next = win_sum[SRC_W-1:0];
  end

  assign slot_free = (state == EMPTY) || out_ready;
  assign grant     = (elig != '0) && slot_free;
  assign cnt_sum   = {1'b0, filtered_cnt} + {12'd0, nfilt};
  assign out_valid = (state == FULL);

  always_comb begin
    req_ready = '0;
    if (aresetn) begin
      req_ready = filt;
      if (grant) req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (grant) state_next = FULL;
      FULL:    if (out_ready && !grant) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= EMPTY;
    else          state <= state_next;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ts           <= '0;
      ptr          <= '0;
      filtered_cnt <= '0;
      out_level    <= '0;
      out_msgid    <= '0;
      out_src      <= '0;
      out_time     <= '0;
    end else begin
      ts           <= ts + 1'b1;
      filtered_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      if (grant) begin
        out_level <= max_lvl;
        out_msgid <= win_msgid;
        out_src   <= winner;
        out_time  <= ts;
        ptr       <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_log_event_arbiter.sv
// Randomized and directed bench for log_event_arbiter: a spec-level model predicts handshakes and
// pushes granted events into a scoreboard that an independent output monitor drains and compares.
module tb_log_event_arbiter;
  localparam int N   = 4;
  localparam int IDW = 8;
  localparam int TSW = 32;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [2:0]       verbosity = 3'd1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [3*N-1:0]   req_level = '0;
  logic [IDW*N-1:0] req_msgid = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [2:0]       out_level;
  logic [IDW-1:0]   out_msgid;
  logic [1:0]       out_src;
  logic [TSW-1:0]   out_time;
  logic [15:0]      filtered_cnt;

  log_event_arbiter #(.NB_REQ(N), .ID_W(IDW), .TS_W(TSW)) dut (
    .aclk(aclk), .aresetn(aresetn), .verbosity(verbosity),
    .req_valid(req_valid), .req_ready(req_ready), .req_level(req_level), .req_msgid(req_msgid),
    .out_valid(out_valid), .out_ready(out_ready), .out_level(out_level), .out_msgid(out_msgid),
    .out_src(out_src), .out_time(out_time), .filtered_cnt(filtered_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [2:0]     level;
    logic [IDW-1:0] msgid;
    int             src;
    logic [TSW-1:0] ts;
  } ev_t;

  int total = 0;
  int bad   = 0;

  // Requester-side stimulus state
  logic [N-1:0]   v = '0;
  logic [2:0]     lv [N];
  logic [IDW-1:0] id [N];

  // Reference model state
  int             m_rr = 0;
  int             m_cnt = 0;
  logic [TSW-1:0] m_ts = '0;
  bit             m_full = 1'b0;
  logic [N-1:0]   m_ready;
  bit             m_grant;
  int             m_win;
  int             m_nfilt;
  ev_t            sb [$];
  logic [N-1:0]   seen_ready;
  int             rr_exp [5] = '{0, 1, 2, 3, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input logic [2:0] l);
    if (l == 3'd0) return 1;
    if (l > 3'd5) return 5;
    return int'(l);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_level[3*i +: 3]   = lv[i];
      req_msgid[IDW*i +: IDW] = id[i];
    end
    req_valid = v;
  endtask

  // Predict this cycle's handshakes from the current inputs and model state.
  task automatic model_eval();
    int vm, best;
    logic [N-1:0] elig;
    vm = eff(verbosity);
    m_ready = '0; elig = '0; m_nfilt = 0; best = 0; m_grant = 1'b0; m_win = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (eff(lv[i]) < vm) begin
          m_ready[i] = 1'b1;
          m_nfilt++;
        end else begin
          elig[i] = 1'b1;
          if (eff(lv[i]) > best) best = eff(lv[i]);
        end
      end
    end
    if (elig != '0 && (!m_full || out_ready)) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (!m_grant && elig[idx] && eff(lv[idx]) == best) begin
          m_grant = 1'b1;
          m_win   = idx;
        end
      end
      m_ready[m_win] = 1'b1;
    end
    if (!aresetn) begin
      m_ready = '0;
      m_grant = 1'b0;
    end
  endtask

  task automatic model_update();
    if (!aresetn) begin
      m_rr = 0; m_cnt = 0; m_ts = '0; m_full = 1'b0;
      sb.delete();
    end else begin
      m_cnt = (m_cnt + m_nfilt > 65535) ? 65535 : m_cnt + m_nfilt;
      if (m_grant) begin
        sb.push_back('{level: 3'(eff(lv[m_win])), msgid: id[m_win], src: m_win, ts: m_ts});
        m_rr   = (m_win + 1) % N;
        m_full = 1'b1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
      m_ts = m_ts + 1'b1;
    end
  endtask

  task automatic step();
    drive();
    @(negedge aclk);
    model_eval();
    seen_ready = req_ready;
    check("req_ready", req_ready, m_ready);
    check("out_valid", out_valid, m_full);
    check("filtered_cnt", filtered_cnt, m_cnt);
    @(posedge aclk);
    model_update();
    #1;
  endtask

  task automatic retire();
    for (int i = 0; i < N; i++) if (m_ready[i]) v[i] = 1'b0;
  endtask

  // Output monitor: compares the held event against the scoreboard head and pops on handshake.
  always @(negedge aclk) begin
    if (aresetn && out_valid) begin
      check("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        check("out_level", out_level, sb[0].level);
        check("out_msgid", out_msgid, sb[0].msgid);
        check("out_src", out_src, sb[0].src);
        check("out_time", out_time, sb[0].ts);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      lv[i] = 3'd3;
      id[i] = 8'(8'h40 + i);
    end

    // Reset with every requester valid
    v = '1; aresetn = 1'b0; out_ready = 1'b1; verbosity = 3'd1;
    repeat (3) begin
      step();
      check("rst_ready", seen_ready, 4'b0000);
    end
    aresetn = 1'b1; v = '0;
    repeat (2) step();

    // Round-robin among equal severities; first grant timestamp = cycles since release
    v = '1;
    step();
    check("rr_first_ready", seen_ready, 4'b0001);
    check("first_time", out_time, 2);
    for (int k = 0; k < 5; k++) begin
      check("rr_src", out_src, rr_exp[k]);
      if (k < 4) step();
    end
    v = '0;
    step();

    // Severity priority
    v = 4'b0101; lv[0] = 3'd2; id[0] = 8'h10; lv[2] = 3'd5; id[2] = 8'h22;
    step();
    check("sev_ready", seen_ready, 4'b0100);
    check("sev_level", out_level, 3'd5);
    check("sev_msgid", out_msgid, 8'h22);
    check("sev_src", out_src, 2);
    retire();
    step();
    check("sev_next_ready", seen_ready, 4'b0001);
    check("sev_next_src", out_src, 0);
    retire();
    step();

    // Filtering and counter saturation
    verbosity = 3'd3; v = 4'b1010; lv[1] = 3'd1; lv[3] = 3'd2;
    step();
    check("filt_ready", seen_ready, 4'b1010);
    check("filt_cnt", filtered_cnt, 16'd2);
    check("filt_out_valid", out_valid, 1'b0);
    repeat (40000) step();
    check("filt_sat", filtered_cnt, 16'hFFFF);
    check("filt_sat_out_valid", out_valid, 1'b0);
    v = '0;

    // Backpressure
    verbosity = 3'd1; out_ready = 1'b0;
    v = 4'b0010; lv[1] = 3'd2; id[1] = 8'h55;
    step();
    retire();
    v[0] = 1'b1; lv[0] = 3'd4; id[0] = 8'h66;
    repeat (5) begin
      step();
      check("bp_ready", seen_ready, 4'b0000);
      check("bp_msgid", out_msgid, 8'h55);
      check("bp_src", out_src, 1);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_ready", seen_ready, 4'b0001);
    check("bp_release_valid", out_valid, 1'b1);
    check("bp_release_src", out_src, 0);
    check("bp_release_msgid", out_msgid, 8'h66);
    retire();

    // Reset while an event is held
    for (int i = 0; i < N; i++) lv[i] = 3'd3;
    v = '1; aresetn = 1'b0;
    step();
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_cnt", filtered_cnt, 16'd0);
    aresetn = 1'b1;
    step();
    check("midrst_ptr", seen_ready, 4'b0001);
    v = '0;
    step();

    // Randomized traffic with backpressure and verbosity changes
    for (int c = 0; c < 3000; c++) begin
      if (c % 16 == 0) verbosity = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!v[i]) begin
          v[i]  = 1'($urandom_range(0, 1));
          lv[i] = 3'($urandom_range(0, 7));
          id[i] = 8'($urandom);
        end
      end
      step();
      retire();
    end

    v = '0; out_ready = 1'b1;
    repeat (3) step();
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
